// File: rtl/maroc_sc_pkg.sv
// maroc_sc_pkg: shared constants and state encoding for the MAROC slow-control readback.
package maroc_sc_pkg;
  localparam int FRAME_LEN = 829;
  localparam int IDX_W = 10;
  localparam int CNT_W = 10;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2, TIMEOUT = 2'd3} state_e;
endpackage

// File: rtl/maroc_sc_crc16.sv
// maroc_sc_crc16: serial CRC-16-CCITT, one bit per enabled cycle, MSB-first shift, no reflection.
module maroc_sc_crc16
  import maroc_sc_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  always_comb
    crc_d = init ? CRC16_INIT :
            en   ? ({crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ din) ? CRC16_POLY : 16'h0000)) : crc_q;
  always_ff @(posedge clk_in)
    if (reset_in) crc_q <= '0;
    else crc_q <= crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/maroc_sc_readback.sv
// maroc_sc_readback: captures the MAROC Q_SC return stream and compares it bit-by-bit with a snapshot.
// Optional CRC-16 over captured bits enabled by defining SC_READBACK_CRC_EN.
module maroc_sc_readback
  import maroc_sc_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic                 ck_sc_in,
  input  logic                 q_sc_in,
  input  logic [FRAME_LEN-1:0] expected_in,
  output logic [FRAME_LEN-1:0] frame_out,
  output logic [IDX_W-1:0]     bit_cnt_out,
  output logic [CNT_W-1:0]     err_count_out,
  output logic [IDX_W-1:0]     first_err_idx_out,
  output logic                 match_out,
  output logic                 done_out,
  output logic                 timeout_out,
  output logic [15:0]          crc_out,
  output logic [1:0]           state_out
);
  state_e               state_q, state_d;
  logic                 ck_q;
  logic [FRAME_LEN-1:0] snap_q, snap_d, frame_q, frame_d;
  logic [IDX_W-1:0]     bit_cnt_q, bit_cnt_d, first_q, first_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 rise, start_ok, cap_en;
  assign rise     = ck_sc_in & ~ck_q;
  assign start_ok = start_in && (state_q != CAPTURE);
  assign cap_en   = (state_q == CAPTURE) && rise;
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    first_d   = first_q;
    err_d     = err_q;
    tmr_d     = tmr_q;
    if (start_ok) begin
      state_d   = CAPTURE;
      snap_d    = expected_in;
      frame_d   = '0;
      bit_cnt_d = '0;
      first_d   = '1;
      err_d     = '0;
      tmr_d     = '0;
    end else if (cap_en) begin
      frame_d[bit_cnt_q] = q_sc_in;
      bit_cnt_d = bit_cnt_q + 1'b1;
      tmr_d     = '0;
      if (q_sc_in != snap_q[bit_cnt_q]) begin
        err_d   = err_q + CNT_W'(err_q != '1);
        first_d = (err_q == '0) ? bit_cnt_q : first_q;
      end
      if (bit_cnt_q == IDX_W'(FRAME_LEN - 1)) state_d = DONE;
    end else if (state_q == CAPTURE) begin
      tmr_d = tmr_q + 1'b1;
      if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) state_d = TIMEOUT;
    end
  end
  always_ff @(posedge clk_in)
    if (reset_in) begin
      state_q   <= IDLE;
      ck_q      <= 1'b0;
      snap_q    <= '0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      first_q   <= '1;
      err_q     <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ck_q      <= ck_sc_in;
      snap_q    <= snap_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      first_q   <= first_d;
      err_q     <= err_d;
      tmr_q     <= tmr_d;
    end
  assign frame_out         = frame_q;
  assign bit_cnt_out       = bit_cnt_q;
  assign err_count_out     = err_q;
  assign first_err_idx_out = first_q;
  assign state_out         = state_q;
  assign match_out         = (state_q == DONE) && (err_q == '0);
  assign done_out          = (state_q == DONE) || (state_q == TIMEOUT);
  assign timeout_out       = state_q == TIMEOUT;
`ifdef SC_READBACK_CRC_EN
  maroc_sc_crc16 u_crc (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .init    (start_ok),
    .en      (cap_en),
    .din     (q_sc_in),
    .crc     (crc_out)
  );
`else
  assign crc_out = 16'h0000;
`endif
endmodule
